imem_arbiter: RTL and testbench
===============================

// Module: imem_arbiter
// PURPOSE
//  Shares the single-port instruction memory between the core fetch port (read-only) and the
//  loader/debug port (read/write). Sequences boot: the core is held until the loader finishes
//  writing the program, then both ports are arbitrated.
//  Sits between IF stage / loader and the instruction memory (1-cycle synchronous read).
// PARAMETERS
//  ADDR_LSB    2  byte-address bits dropped to form word index (m_addr = addr >> ADDR_LSB)
//  STARVE_MAX  4  max consecutive loader grants while fetch waits (fixed-priority mode only)
//  NOP_INST    32'h0000_0013  data returned for out-of-range reads
// PORTS
//  clk          in   1             clock
//  rst_n        in   1             async active-low reset
//  f_req        in   1             fetch read request
//  f_addr       in   InstAddrBus   fetch byte address
//  f_gnt        out  1             fetch request accepted this cycle
//  f_rvalid     out  1             fetch data valid (cycle after f_gnt)
//  f_rdata      out  InstBus       fetch data
//  l_req        in   1             loader request
//  l_we         in   1             loader write (1) / read (0)
//  l_addr       in   InstAddrBus   loader byte address
//  l_wdata      in   InstBus       loader write data
//  l_gnt        out  1             loader request accepted
//  l_rvalid     out  1             loader read data / write ack (cycle after l_gnt)
//  l_rdata      out  InstBus       loader read data (0 on write ack)
//  l_boot_done  in   1             loader pulse: program loaded, release core
//  core_run     out  1             1 in RUN state; core must not fetch while 0
//  m_en, m_we   out  1,1           memory enable / write enable
//  m_addr       out  InstAddrBus   memory word index
//  m_wdata      out  InstBus       memory write data
//  m_rdata      in   InstBus       memory read data, valid cycle after m_en
// BEHAVIOUR
//  - Clock clk, reset rst_n: one clock; reset asynchronous, active-low.
//  - Reset: state=BOOT; all outputs 0; pending response, owner, starve count cleared.
//    Reset mid-transfer drops the pending rvalid.
//  - FSM:
//    - BOOT: only loader served; f_gnt=0; l_boot_done -> RUN (next cycle).
//    - RUN: both arbitrated; never returns to BOOT except by reset. l_boot_done in RUN ignored.
//  - Grant is combinational: at most one of f_gnt/l_gnt per cycle, only when its req=1.
//    m_en=f_gnt|l_gnt; m_* driven from the winner in the same cycle.
//  - Response: registered owner; winner's rvalid=1 exactly one cycle after gnt, rdata from m_rdata.
//    Back-to-back grants give one response per cycle, no bubbles.
//  - Requester holds req/addr until gnt; gnt ends that request.
//  - Arbitration (default, fixed priority): loader wins ties. Starve counter increments on each
//    loader grant while f_req=1, clears on fetch grant or f_req=0. At STARVE_MAX, fetch wins the
//    next tie.
//  - Out-of-range: word index >= mem_inst_size.
//    - Read: granted, m_en=0, rvalid next cycle with rdata=NOP_INST.
//    - Write: granted and dropped; ack still given.
//  - Write ack: l_rvalid=1, l_rdata=0.
// CONFIGURATION
//  IMEM_ARB_RR_EN defined: round-robin in RUN; on a tie, the port not granted last wins;
//    starve counter and STARVE_MAX unused. BOOT unchanged.
//  Undefined: fixed priority with starvation limit as above.
// STRUCTURE
//  - InstAddrBus, InstBus, mem_inst_size, NOP constant come from the shared define_core.v header.
//  - Sub-module imem_arb_pick: winner select + last-owner / starve-count state.
//    Top holds the FSM, response pipeline and memory muxing.
// TESTING
//  1. Reset then f_req=1, l_req=0 in BOOT -> f_gnt=0, core_run=0.
//     l_boot_done pulse -> core_run=1 next cycle.
//  2. BOOT: loader writes 0xDEADBEEF @0x10, reads @0x10
//     -> m_addr=4, m_we=1; l_rdata=0xDEADBEEF one cycle after read gnt.
//  3. RUN, f_req and l_req both held 10 cycles (fixed priority, STARVE_MAX=4)
//     -> pattern L,L,L,L,F repeating.
//     With IMEM_ARB_RR_EN -> L,F,L,F.
//  4. Fetch back-to-back @0,4,8 -> f_rvalid=1 three consecutive cycles, data in order.
//  5. Fetch read at word index mem_inst_size -> f_rvalid next cycle, f_rdata=0x00000013, m_en=0.
//  6. Assert rst_n=0 the cycle after f_gnt -> f_rvalid stays 0; state=BOOT, core_run=0.

Source files
------------

// File: rtl/imem_arbiter_pkg.sv
// Shared types and constants for the instruction-memory arbiter slice:
// bus widths, memory depth, the NOP encoding and the boot/run state type.
package imem_arbiter_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t MEM_INST_SIZE = 32'd1024;
    localparam inst_t      INST_NOP      = 32'h0000_0013;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    function automatic inst_addr_t word_index(input inst_addr_t addr, input int unsigned lsb);
        return addr >> lsb;
    endfunction

    function automatic logic idx_in_range(input inst_addr_t idx);
        return idx < MEM_INST_SIZE;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader, boot-control and memory-side signals of the instruction-memory arbiter.
// The arbiter connects through the slave modport; requesters/memory use master.
interface imem_arbiter_if;
    import imem_arbiter_pkg::*;

    logic       f_req;
    inst_addr_t f_addr;
    logic       f_gnt;
    logic       f_rvalid;
    inst_t      f_rdata;

    logic       l_req;
    logic       l_we;
    inst_addr_t l_addr;
    inst_t      l_wdata;
    logic       l_gnt;
    logic       l_rvalid;
    inst_t      l_rdata;

    logic       l_boot_done;
    logic       core_run;

    logic       m_en;
    logic       m_we;
    inst_addr_t m_addr;
    inst_t      m_wdata;
    inst_t      m_rdata;

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_boot_done, m_rdata,
        output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, core_run,
               m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_boot_done, m_rdata,
        input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, core_run,
               m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/imem_arbiter_pick.sv
// Winner select for the instruction-memory arbiter (module imem_arb_pick).
// Default: loader priority with a starvation limit; IMEM_ARB_RR_EN selects round-robin in RUN.
module imem_arb_pick
    import imem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_f_req,
    input  logic i_l_req,
    output logic o_f_gnt,
    output logic o_l_gnt
);

    logic w_f_wins_tie;

`ifdef IMEM_ARB_RR_EN
    // Cleared owner means "fetch went last", so the loader takes the first tie.
    logic r_last_l;

    assign w_f_wins_tie = r_last_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_l <= 1'b0;
        end else if (i_run && (o_f_gnt || o_l_gnt)) begin
            r_last_l <= o_l_gnt;
        end
    end
`else
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] r_starve;

    assign w_f_wins_tie = (r_starve >= STARVE_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!i_run || !i_f_req || o_f_gnt) begin
            r_starve <= '0;
        end else if (o_l_gnt && (r_starve < STARVE_LIM)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`endif

    // Grants are forced low while reset is asserted so every output reads 0.
    always_comb begin
        o_f_gnt = 1'b0;
        o_l_gnt = 1'b0;
        if (!rst_n) begin
            o_f_gnt = 1'b0;
        end else if (!i_run) begin
            o_l_gnt = i_l_req;
        end else if (i_f_req && i_l_req) begin
            o_f_gnt = w_f_wins_tie;
            o_l_gnt = !w_f_wins_tie;
        end else begin
            o_f_gnt = i_f_req;
            o_l_gnt = i_l_req;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter top: boot/run FSM, memory-side muxing and the one-cycle response path.
// Optional build macro IMEM_ARB_RR_EN switches RUN-state arbitration to round-robin.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int    ADDR_LSB   = 2,
    parameter int    STARVE_MAX = 4,
    parameter inst_t NOP_INST   = INST_NOP
) (
    input  logic          clk,
    input  logic          rst_n,
    imem_arbiter_if.slave bus
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;
    logic       w_run;

    logic       w_f_gnt;
    logic       w_l_gnt;
    logic       w_any_gnt;
    inst_addr_t w_addr;
    inst_addr_t w_idx;
    logic       w_in_range;
    logic       w_m_en;
    logic       w_m_we;
    inst_t      w_rsp_data;

    logic       r_f_vld_p1;
    logic       r_l_vld_p1;
    logic       r_nop_p1;
    logic       r_wack_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // RUN is sticky until reset; a late boot-done pulse is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        case (r_state)
            ST_BOOT: begin
                if (bus.l_boot_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_BOOT;
            end
        endcase
    end

    imem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_run   (w_run),
        .i_f_req (bus.f_req),
        .i_l_req (bus.l_req),
        .o_f_gnt (w_f_gnt),
        .o_l_gnt (w_l_gnt)
    );

    // Stage p0: winner drives the memory port in the grant cycle.
    assign w_any_gnt  = w_f_gnt | w_l_gnt;
    assign w_addr     = w_l_gnt ? bus.l_addr : bus.f_addr;
    assign w_idx      = word_index(w_addr, ADDR_LSB);
    assign w_in_range = idx_in_range(w_idx);
    assign w_m_en     = w_any_gnt & w_in_range;
    assign w_m_we     = w_l_gnt & bus.l_we & w_in_range;

    assign bus.f_gnt    = w_f_gnt;
    assign bus.l_gnt    = w_l_gnt;
    assign bus.core_run = w_run;
    assign bus.m_en     = w_m_en;
    assign bus.m_we     = w_m_we;
    assign bus.m_addr   = w_m_en ? w_idx : '0;
    assign bus.m_wdata  = w_m_we ? bus.l_wdata : '0;

    // Stage p1: response owner and data source, one cycle after the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f_vld_p1 <= 1'b0;
            r_l_vld_p1 <= 1'b0;
            r_nop_p1   <= 1'b0;
            r_wack_p1  <= 1'b0;
        end else begin
            r_f_vld_p1 <= w_f_gnt;
            r_l_vld_p1 <= w_l_gnt;
            r_nop_p1   <= w_any_gnt & !w_in_range;
            r_wack_p1  <= w_l_gnt & bus.l_we;
        end
    end

    assign w_rsp_data   = r_nop_p1 ? NOP_INST : bus.m_rdata;
    assign bus.f_rvalid = r_f_vld_p1;
    assign bus.f_rdata  = r_f_vld_p1 ? w_rsp_data : '0;
    assign bus.l_rvalid = r_l_vld_p1;
    assign bus.l_rdata  = (r_l_vld_p1 && !r_wack_p1) ? w_rsp_data : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: cycle table for boot, arbitration, streaming and
// out-of-range accesses, plus hand-written reset and mid-transfer reset sequences.
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    typedef struct {
        bit          f_req;
        logic [31:0] f_addr;
        bit          l_req;
        bit          l_we;
        logic [31:0] l_addr;
        logic [31:0] l_wdata;
        bit          boot;
        bit          e_f_gnt;
        bit          e_l_gnt;
        bit          e_m_en;
        bit          e_m_we;
        logic [31:0] e_m_addr;
        logic [31:0] e_m_wdata;
        bit          e_f_vld;
        logic [31:0] e_f_data;
        bit          e_l_vld;
        logic [31:0] e_l_data;
        bit          e_run;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    vec_t tbl[$];

    imem_arbiter_if bus ();

    imem_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    inst_t mem [0:1023];
    inst_t r_mrd;

    initial begin
        clk = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | i;
    end

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr[9:0]] <= bus.m_wdata;
            else          r_mrd <= mem[bus.m_addr[9:0]];
        end
    end

    assign bus.m_rdata = r_mrd;

    function automatic vec_t rq(int fr, logic [31:0] fa, int lr, int lw, logic [31:0] la,
                                logic [31:0] ld, int bd, int run);
        vec_t v;
        v = '{default: '0};
        v.f_req = (fr != 0); v.f_addr = fa; v.l_req = (lr != 0); v.l_we = (lw != 0);
        v.l_addr = la; v.l_wdata = ld; v.boot = (bd != 0); v.e_run = (run != 0);
        return v;
    endfunction

    function automatic vec_t gn(vec_t vi, int fg, int lg, int en, int we, logic [31:0] a,
                                logic [31:0] d);
        vec_t v = vi;
        v.e_f_gnt = (fg != 0); v.e_l_gnt = (lg != 0); v.e_m_en = (en != 0);
        v.e_m_we = (we != 0); v.e_m_addr = a; v.e_m_wdata = d;
        return v;
    endfunction

    function automatic vec_t rs(vec_t vi, int fv, logic [31:0] fd, int lv, logic [31:0] ldt);
        vec_t v = vi;
        v.e_f_vld = (fv != 0); v.e_f_data = fd; v.e_l_vld = (lv != 0); v.e_l_data = ldt;
        return v;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.f_req = 1'b0; bus.f_addr = '0; bus.l_req = 1'b0; bus.l_we = 1'b0;
        bus.l_addr = '0; bus.l_wdata = '0; bus.l_boot_done = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        bus.f_req = v.f_req; bus.f_addr = v.f_addr; bus.l_req = v.l_req; bus.l_we = v.l_we;
        bus.l_addr = v.l_addr; bus.l_wdata = v.l_wdata; bus.l_boot_done = v.boot;
    endtask

    task automatic check_row(input int r, input vec_t v);
        chk("f_gnt", r, 32'(bus.f_gnt), 32'(v.e_f_gnt));
        chk("l_gnt", r, 32'(bus.l_gnt), 32'(v.e_l_gnt));
        chk("m_en", r, 32'(bus.m_en), 32'(v.e_m_en));
        chk("m_we", r, 32'(bus.m_we), 32'(v.e_m_we));
        chk("core_run", r, 32'(bus.core_run), 32'(v.e_run));
        chk("f_rvalid", r, 32'(bus.f_rvalid), 32'(v.e_f_vld));
        chk("l_rvalid", r, 32'(bus.l_rvalid), 32'(v.e_l_vld));
        if (v.e_m_en) chk("m_addr", r, bus.m_addr, v.e_m_addr);
        if (v.e_m_we) chk("m_wdata", r, bus.m_wdata, v.e_m_wdata);
        if (v.e_f_vld) chk("f_rdata", r, bus.f_rdata, v.e_f_data);
        if (v.e_l_vld) chk("l_rdata", r, bus.l_rdata, v.e_l_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   fw;
        int   pw;
        n_cmp = 0;
        n_err = 0;

        // Boot: fetch ignored, loader write then read of byte 0x10 (word 4), boot-done.
        tbl.push_back(rq(1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(gn(rq(1, 0, 1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0), 0, 1, 1, 1, 4, 32'hDEAD_BEEF));
        tbl.push_back(rs(gn(rq(1, 0, 1, 0, 32'h10, 0, 0, 0), 0, 1, 1, 0, 4, 0), 0, 0, 1, 0));
        tbl.push_back(rs(rq(1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 32'hDEAD_BEEF));
        tbl.push_back(rq(1, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(rq(0, 0, 0, 0, 0, 0, 0, 1));
        // Contention for 10 cycles; boot-done pulse in RUN at k=2 must be ignored.
        pw = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef IMEM_ARB_RR_EN
            fw = (k % 2 == 1) ? 1 : 0;
`else
            fw = (k % 5 == 4) ? 1 : 0;
`endif
            v = gn(rq(1, 32'h20, 1, 0, 32'h10, 0, (k == 2) ? 1 : 0, 1), fw, 1 - fw, 1, 0,
                   (fw != 0) ? 32'd8 : 32'd4, 0);
            if (k > 0) v = rs(v, pw, 32'hC0DE_0008, 1 - pw, 32'hDEAD_BEEF);
            tbl.push_back(v);
            pw = fw;
        end
        tbl.push_back(rs(rq(0, 0, 0, 0, 0, 0, 0, 1), 1, 32'hC0DE_0008, 0, 0));
        // Back-to-back fetches, then an out-of-range fetch at word MEM_INST_SIZE.
        tbl.push_back(gn(rq(1, 0, 0, 0, 0, 0, 0, 1), 1, 0, 1, 0, 0, 0));
        tbl.push_back(rs(gn(rq(1, 4, 0, 0, 0, 0, 0, 1), 1, 0, 1, 0, 1, 0), 1, 32'hC0DE_0000, 0, 0));
        tbl.push_back(rs(gn(rq(1, 8, 0, 0, 0, 0, 0, 1), 1, 0, 1, 0, 2, 0), 1, 32'hC0DE_0001, 0, 0));
        tbl.push_back(rs(gn(rq(1, 32'h1000, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0), 1, 32'hC0DE_0002, 0, 0));
        // Out-of-range loader write (dropped, acked) and read (NOP).
        tbl.push_back(rs(gn(rq(0, 0, 1, 1, 32'h1000, 32'h1234_5678, 0, 1), 0, 1, 0, 0, 0, 0), 1, 32'h13, 0, 0));
        tbl.push_back(rs(gn(rq(0, 0, 1, 0, 32'h1004, 0, 0, 1), 0, 1, 0, 0, 0, 0), 0, 0, 1, 0));
        tbl.push_back(rs(rq(0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 1, 32'h13));

        // Reset state with both requests high.
        rst_n = 1'b0;
        drive_idle();
        bus.f_req = 1'b1;
        bus.l_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_f_gnt", -1, 32'(bus.f_gnt), 0);
        chk("rst_l_gnt", -1, 32'(bus.l_gnt), 0);
        chk("rst_m_en", -1, 32'(bus.m_en), 0);
        chk("rst_core_run", -1, 32'(bus.core_run), 0);
        chk("rst_f_rvalid", -1, 32'(bus.f_rvalid), 0);
        chk("rst_l_rvalid", -1, 32'(bus.l_rvalid), 0);
        drive_idle();
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            check_row(i, tbl[i]);
            @(posedge clk); #1;
        end

        // Reset the cycle after a fetch grant: the pending response must vanish.
        drive_idle();
        bus.f_req = 1'b1;
        bus.f_addr = 32'h8;
        @(negedge clk);
        chk("mid_f_gnt", 100, 32'(bus.f_gnt), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.f_req = 1'b0;
        @(negedge clk);
        chk("mid_f_rvalid", 101, 32'(bus.f_rvalid), 0);
        chk("mid_core_run", 101, 32'(bus.core_run), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.f_req = 1'b1;
        @(negedge clk);
        chk("post_f_gnt", 102, 32'(bus.f_gnt), 0);
        chk("post_core_run", 102, 32'(bus.core_run), 0);
        chk("post_f_rvalid", 102, 32'(bus.f_rvalid), 0);
        @(posedge clk); #1;
        bus.f_req = 1'b0;
        @(negedge clk);
        chk("post2_f_rvalid", 103, 32'(bus.f_rvalid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
